// File: rtl/pc_redirect_ctrl.sv
// Fetch PC redirect sequencer: arbitrates exception/branch redirects, buffers one
// until fetch accepts it, delivers it through the PC flush path, and holds the PC during boot.
module pc_redirect_ctrl #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(32'h1c000000),
    parameter int                    BOOT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  excp_valid_i,
    input  logic [ADDR_WIDTH-1:0] excp_pc_i,
    input  logic                  br_valid_i,
    input  logic [ADDR_WIDTH-1:0] br_target_i,
    input  logic                  stall_i,
    input  logic                  if_ready_i,
    output logic                  pc_stall_o,
    output logic                  pc_flush_o,
    output logic [ADDR_WIDTH-1:0] pc_new_pc_o,
    output logic                  fe_flush_o,
    output logic                  redirect_busy_o,
    output logic [31:0]           redirect_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] BOOT_INIT = 8'(BOOT_CYCLES);

    state_t                state_q, state_d;
    logic [7:0]            boot_cnt_q, boot_cnt_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_exc_q, pend_exc_d;
    logic [ADDR_WIDTH-1:0] pend_target_q, pend_target_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    logic                  active;
    logic                  cand_valid;
    logic                  cand_exc;
    logic [ADDR_WIDTH-1:0] cand_target;
    logic                  issue;

    // Candidate priority: incoming exception, then the pending entry, then an incoming branch.
    // A branch arriving while something is pending is simply never selected, i.e. dropped.
    always_comb begin
        cand_valid  = 1'b0;
        cand_exc    = 1'b0;
        cand_target = RESET_PC;
        if (excp_valid_i) begin
            cand_valid  = 1'b1;
            cand_exc    = 1'b1;
            cand_target = excp_pc_i;
        end else if (pend_valid_q) begin
            cand_valid  = 1'b1;
            cand_exc    = pend_exc_q;
            cand_target = pend_target_q;
        end else if (br_valid_i) begin
            cand_valid  = 1'b1;
            cand_exc    = 1'b0;
            cand_target = br_target_i;
        end
    end

    assign active = (state_q != ST_BOOT);
    assign issue  = active & cand_valid & if_ready_i & (cand_exc | ~stall_i);

    always_comb begin
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        pend_valid_d  = pend_valid_q;
        pend_exc_d    = pend_exc_q;
        pend_target_d = pend_target_q;
        cnt_d         = cnt_q;
        case (state_q)
            ST_BOOT: begin
                pend_valid_d = 1'b0;
                if (boot_cnt_q <= 8'd1) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - 8'd1;
                end
            end
            default: begin
                if (issue) begin
                    pend_valid_d = 1'b0;
                    state_d      = ST_RUN;
                    cnt_d        = cnt_q + 32'd1;
                end else if (cand_valid) begin
                    pend_valid_d  = 1'b1;
                    pend_exc_d    = cand_exc;
                    pend_target_d = cand_target;
                    state_d       = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
        busy_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_BOOT;
            boot_cnt_q    <= BOOT_INIT;
            pend_valid_q  <= 1'b0;
            pend_exc_q    <= 1'b0;
            pend_target_q <= RESET_PC;
            cnt_q         <= 32'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_exc_q    <= pend_exc_d;
            pend_target_q <= pend_target_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
        end
    end

    // Flush overrides stall in the PC register, so an issuing cycle out of HOLD must not stall.
    assign pc_flush_o      = issue;
    assign fe_flush_o      = issue;
    assign pc_new_pc_o     = issue ? cand_target : RESET_PC;
    assign pc_stall_o      = ~active | stall_i | ~if_ready_i | ((state_q == ST_HOLD) & ~issue);
    assign redirect_busy_o = busy_q;
    assign redirect_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed vector table, hand-written
// reset/boot sequences, and randomized traffic checked against a queue-based reference model.
module tb_pc_redirect_ctrl;

    localparam int          AW       = 32;
    localparam logic [31:0] RST_PC   = 32'h1c000000;
    localparam int          BOOT_CYC = 4;

    logic          clk;
    logic          rst;
    logic          excp_valid_i;
    logic [AW-1:0] excp_pc_i;
    logic          br_valid_i;
    logic [AW-1:0] br_target_i;
    logic          stall_i;
    logic          if_ready_i;
    logic          pc_stall_o;
    logic          pc_flush_o;
    logic [AW-1:0] pc_new_pc_o;
    logic          fe_flush_o;
    logic          redirect_busy_o;
    logic [31:0]   redirect_cnt_o;

    int checks   = 0;
    int failures = 0;

    pc_redirect_ctrl #(
        .ADDR_WIDTH (AW),
        .RESET_PC   (RST_PC),
        .BOOT_CYCLES(BOOT_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .excp_valid_i   (excp_valid_i),
        .excp_pc_i      (excp_pc_i),
        .br_valid_i     (br_valid_i),
        .br_target_i    (br_target_i),
        .stall_i        (stall_i),
        .if_ready_i     (if_ready_i),
        .pc_stall_o     (pc_stall_o),
        .pc_flush_o     (pc_flush_o),
        .pc_new_pc_o    (pc_new_pc_o),
        .fe_flush_o     (fe_flush_o),
        .redirect_busy_o(redirect_busy_o),
        .redirect_cnt_o (redirect_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [31:0] epc;
        logic        bv;
        logic [31:0] btgt;
        logic        stall;
        logic        ready;
        logic        x_flush;
        logic [31:0] x_pc;
        logic        x_stall;
        logic        x_busy;
        logic [31:0] x_cnt;
    } vec_t;

    typedef struct {
        bit          exc;
        logic [31:0] tgt;
    } redir_t;

    // Reference model: remaining boot cycles, a 0/1-deep pending queue, and an issue counter.
    int          m_boot_left;
    redir_t      m_pend[$];
    int unsigned m_cnt;
    bit          m_issue;
    bit          m_have;
    redir_t      m_cand;

    function automatic vec_t mk(logic ev, logic [31:0] epc, logic bv, logic [31:0] btgt,
                                logic stall, logic ready, logic x_flush, logic [31:0] x_pc,
                                logic x_stall, logic x_busy, logic [31:0] x_cnt);
        vec_t v;
        v.ev = ev; v.epc = epc; v.bv = bv; v.btgt = btgt; v.stall = stall; v.ready = ready;
        v.x_flush = x_flush; v.x_pc = x_pc; v.x_stall = x_stall; v.x_busy = x_busy; v.x_cnt = x_cnt;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%0h want=%0h at t=%0t", name, got, want, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic x_flush, input logic [31:0] x_pc,
                               input logic x_stall, input logic x_busy, input logic [31:0] x_cnt);
        cmp({tag, ".pc_flush"}, {31'd0, pc_flush_o}, {31'd0, x_flush});
        cmp({tag, ".fe_flush"}, {31'd0, fe_flush_o}, {31'd0, x_flush});
        cmp({tag, ".new_pc"}, pc_new_pc_o, x_pc);
        cmp({tag, ".pc_stall"}, {31'd0, pc_stall_o}, {31'd0, x_stall});
        cmp({tag, ".busy"}, {31'd0, redirect_busy_o}, {31'd0, x_busy});
        cmp({tag, ".cnt"}, redirect_cnt_o, x_cnt);
    endtask

    task automatic drive(input logic ev, input logic [31:0] epc, input logic bv,
                         input logic [31:0] btgt, input logic stall, input logic ready);
        excp_valid_i = ev;
        excp_pc_i    = epc;
        br_valid_i   = bv;
        br_target_i  = btgt;
        stall_i      = stall;
        if_ready_i   = ready;
    endtask

    // Drives one cycle of a vector (called right after a falling edge), checks, waits for next falling edge.
    task automatic applyStimulus(input string tag, input vec_t v);
        drive(v.ev, v.epc, v.bv, v.btgt, v.stall, v.ready);
        #1;
        checkOutput(tag, v.x_flush, v.x_pc, v.x_stall, v.x_busy, v.x_cnt);
        @(negedge clk);
    endtask

    task automatic modelReset();
        m_boot_left = BOOT_CYC;
        m_pend.delete();
        m_cnt = 0;
    endtask

    task automatic modelCheck(input string tag);
        logic [31:0] x_pc;
        logic        x_stall;
        logic        x_busy;
        x_busy  = (m_pend.size() != 0);
        m_have  = 1'b0;
        m_issue = 1'b0;
        m_cand.exc = 1'b0;
        m_cand.tgt = RST_PC;
        if (m_boot_left > 0) begin
            x_stall = 1'b1;
        end else begin
            if (excp_valid_i) begin
                m_have = 1'b1; m_cand.exc = 1'b1; m_cand.tgt = excp_pc_i;
            end else if (m_pend.size() != 0) begin
                m_have = 1'b1; m_cand = m_pend[0];
            end else if (br_valid_i) begin
                m_have = 1'b1; m_cand.exc = 1'b0; m_cand.tgt = br_target_i;
            end
            m_issue = m_have && if_ready_i && (m_cand.exc || !stall_i);
            x_stall = stall_i || !if_ready_i || (x_busy && !m_issue);
        end
        x_pc = m_issue ? m_cand.tgt : RST_PC;
        checkOutput(tag, m_issue, x_pc, x_stall, x_busy, m_cnt);
    endtask

    task automatic modelAdvance();
        if (m_boot_left > 0) begin
            m_boot_left--;
        end else if (m_issue) begin
            m_pend.delete();
            m_cnt++;
        end else if (m_have) begin
            m_pend.delete();
            m_pend.push_back(m_cand);
        end
    endtask

    vec_t vecs[22];

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 0, 1, 0, RST_PC, 1, 0, 0);
        vecs[1]  = mk(0, 0, 1, 32'h1c000100, 0, 1, 0, RST_PC, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 1, 0, RST_PC, 1, 0, 0);
        vecs[3]  = mk(1, 32'h1c008000, 0, 0, 0, 1, 0, RST_PC, 1, 0, 0);
        vecs[4]  = mk(0, 0, 1, 32'h1c000100, 0, 1, 1, 32'h1c000100, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 1, 0, RST_PC, 0, 0, 1);
        vecs[6]  = mk(0, 0, 1, 32'h1c000200, 1, 1, 0, RST_PC, 1, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0, 1, 1, 0, RST_PC, 1, 1, 1);
        vecs[8]  = mk(0, 0, 0, 0, 1, 1, 0, RST_PC, 1, 1, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 1, 1, 32'h1c000200, 0, 1, 1);
        vecs[10] = mk(0, 0, 0, 0, 0, 1, 0, RST_PC, 0, 0, 2);
        vecs[11] = mk(0, 0, 1, 32'h1c000300, 0, 0, 0, RST_PC, 1, 0, 2);
        vecs[12] = mk(1, 32'h1c008000, 0, 0, 0, 0, 0, RST_PC, 1, 1, 2);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, RST_PC, 1, 1, 2);
        vecs[14] = mk(0, 0, 0, 0, 0, 1, 1, 32'h1c008000, 0, 1, 2);
        vecs[15] = mk(0, 0, 0, 0, 0, 1, 0, RST_PC, 0, 0, 3);
        vecs[16] = mk(1, 32'h1c008000, 1, 32'h1c000400, 1, 1, 1, 32'h1c008000, 1, 0, 3);
        vecs[17] = mk(0, 0, 0, 0, 0, 1, 0, RST_PC, 0, 0, 4);
        vecs[18] = mk(0, 0, 1, 32'h1c000500, 0, 0, 0, RST_PC, 1, 0, 4);
        vecs[19] = mk(0, 0, 1, 32'h1c000600, 0, 0, 0, RST_PC, 1, 1, 4);
        vecs[20] = mk(0, 0, 0, 0, 0, 1, 1, 32'h1c000500, 0, 1, 4);
        vecs[21] = mk(0, 0, 0, 0, 0, 1, 0, RST_PC, 0, 0, 5);

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        #1;
        checkOutput("reset", 0, RST_PC, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_held", 0, RST_PC, 1, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while a branch is pending: the entry must vanish and boot must restart.
        applyStimulus("hold_enter", mk(0, 0, 1, 32'h1c000700, 0, 0, 0, RST_PC, 1, 0, 5));
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("hold_busy", 0, RST_PC, 1, 1, 5);
        #1;
        if_ready_i = 1'b1;
        rst = 1'b0;
        #1;
        checkOutput("mid_reset", 0, RST_PC, 1, 0, 0);
        @(negedge clk);
        checkOutput("mid_reset_held", 0, RST_PC, 1, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < BOOT_CYC; i++) begin
            applyStimulus($sformatf("reboot%0d", i), mk(0, 0, 0, 0, 0, 1, 0, RST_PC, 1, 0, 0));
        end
        applyStimulus("post_reboot", mk(0, 0, 0, 0, 0, 1, 0, RST_PC, 0, 0, 0));
        applyStimulus("post_reboot_br", mk(0, 0, 1, 32'h1c000800, 0, 1, 1, 32'h1c000800, 0, 0, 0));
        applyStimulus("post_reboot_cnt", mk(0, 0, 0, 0, 0, 1, 0, RST_PC, 0, 0, 1));

        // Randomized traffic against the reference model.
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 7) == 0), $urandom(),
                  ($urandom_range(0, 3) == 0), $urandom(),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
            #1;
            modelCheck($sformatf("rand%0d", c));
            modelAdvance();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
